// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN2BCD_SIGNED_EN for two's-complement input (adds a negation stage, sets neg).
module bin2bcd_seq_ctrl #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
   output logic                  neg,
   output logic                  busy
);
   localparam int AW = 4*DIGITS;
   localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   typedef enum logic [1:0] {IDLE, NEGATE, SHIFT, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [AW-1:0] acc, acc_n, adj;
   logic [BIN_W-1:0] sh, sh_n;
   logic ovf_r, ovf_n, neg_r, neg_n;

   always_comb begin
      adj = acc;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      acc_n   = acc;
      sh_n    = sh;
      ovf_n   = ovf_r;
      neg_n   = neg_r;
      if (en) begin
         case (state)
            IDLE: if (in_valid) begin
               acc_n = '0;
               ovf_n = 1'b0;
               cnt_n = CW'(BIN_W-1);
               sh_n  = bin;
`ifdef BIN2BCD_SIGNED_EN
               neg_n   = bin[BIN_W-1];
               state_n = NEGATE;
`else
               state_n = SHIFT;
`endif
            end
            NEGATE: begin
               sh_n    = neg_r ? -sh : sh;
               state_n = SHIFT;
            end
            SHIFT: begin
               // a 1 leaving the accumulator means the value needs more digits
               {acc_n, sh_n} = {adj, sh} << 1;
               ovf_n = ovf_r | adj[AW-1];
               cnt_n = cnt - 1'b1;
               if (cnt == '0) state_n = DONE;
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         sh    <= '0;
         ovf_r <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         acc   <= acc_n;
         sh    <= sh_n;
         ovf_r <= ovf_n;
         neg_r <= neg_n;
      end
   end

   assign in_ready  = (state == IDLE) && en;
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);
   assign ovf       = ovf_r;
   assign neg       = neg_r;
   assign bcd       = ovf_r ? {DIGITS{4'h9}} : acc;
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb_bin2bcd_seq_ctrl: directed test of bin2bcd_seq_ctrl at DIGITS=3 and DIGITS=2 side by side.
module tb_bin2bcd_seq_ctrl;
`ifdef BIN2BCD_SIGNED_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT = 8 + EXTRA;
   logic clk = 0, rst = 1, en = 0, in_valid = 0, out_ready = 0;
   logic [7:0] bin = '0;
   logic in_ready3, out_valid3, ovf3, neg3, busy3;
   logic in_ready2, out_valid2, ovf2, neg2, busy2;
   logic [11:0] bcd3;
   logic [7:0] bcd2;
   int total = 0, bad = 0;

   bin2bcd_seq_ctrl #(.BIN_W(8), .DIGITS(3)) u3 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready3), .bin(bin),
      .out_valid(out_valid3), .out_ready(out_ready), .bcd(bcd3), .ovf(ovf3), .neg(neg3), .busy(busy3));
   bin2bcd_seq_ctrl #(.BIN_W(8), .DIGITS(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready2), .bin(bin),
      .out_valid(out_valid2), .out_ready(out_ready), .bcd(bcd2), .ovf(ovf2), .neg(neg2), .busy(busy2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic convert(input logic [7:0] v, input logic [11:0] e3, input logic [7:0] e2,
                          input logic eo2, input logic eneg, input int hold, input bit stall);
      int cyc, nbusy, lat;
      bit ok;
      bin = v;
      in_valid = 1;
      check("in_ready", in_ready3, 1);
      @(posedge clk);
      #1 in_valid = 0;
      bin = 8'h5A;
      @(negedge clk);
      cyc = 0; nbusy = 0; ok = 1;
      while (!out_valid3 && cyc < 40) begin
         if (in_ready3 || in_ready2) ok = 0;
         if (busy3) nbusy++;
         if (stall && cyc == 2) en = 0;
         if (stall && cyc == 5) en = 1;
         @(negedge clk);
         cyc++;
      end
      lat = stall ? LAT + 3 : LAT;
      check("latency", cyc, lat);
      check("busy_cycles", nbusy, lat - EXTRA);
      check("no_ready", ok, 1);
      check("valid2", out_valid2, 1);
      check("bcd3", bcd3, e3);
      check("ovf3", ovf3, 0);
      check("bcd2", bcd2, e2);
      check("ovf2", ovf2, eo2);
      check("neg", neg3, eneg);
      if (hold > 0) begin
         ok = 1;
         repeat (hold) begin
            @(negedge clk);
            if (!out_valid3 || bcd3 !== e3 || in_ready3) ok = 0;
         end
         check("hold", ok, 1);
      end
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
      @(negedge clk);
      check("idle", {out_valid3, in_ready3}, 2'b01);
   endtask

   initial begin
      #2;
      check("rst_ready", in_ready3, 0);
      check("rst_outs", {out_valid3, busy3, ovf3, neg3}, 4'b0000);
      check("rst_bcd", bcd3, 12'h000);
      @(negedge clk);
      rst = 0;
      check("ready_no_en", in_ready3, 0);
      en = 1;
      @(negedge clk);
`ifdef BIN2BCD_SIGNED_EN
      convert(8'h80, 12'h128, 8'h99, 1, 1, 0, 0);
      convert(8'hFF, 12'h001, 8'h01, 0, 1, 0, 0);
      convert(8'h00, 12'h000, 8'h00, 0, 0, 0, 0);
      convert(8'h09, 12'h009, 8'h09, 0, 0, 0, 0);
      convert(8'h9C, 12'h100, 8'h99, 1, 1, 0, 0);
      convert(8'd99, 12'h099, 8'h99, 0, 0, 5, 0);
      convert(8'hC8, 12'h056, 8'h56, 0, 1, 0, 1);
`else
      convert(8'd255, 12'h255, 8'h99, 1, 0, 0, 0);
      convert(8'd0,   12'h000, 8'h00, 0, 0, 0, 0);
      convert(8'd9,   12'h009, 8'h09, 0, 0, 0, 0);
      convert(8'd200, 12'h200, 8'h99, 1, 0, 0, 0);
      convert(8'd99,  12'h099, 8'h99, 0, 0, 0, 0);
      convert(8'd128, 12'h128, 8'h99, 1, 0, 5, 0);
      convert(8'd173, 12'h173, 8'h99, 1, 0, 0, 1);
      convert(8'd47,  12'h047, 8'h47, 0, 0, 0, 0);
`endif
      bin = 8'd77;
      in_valid = 1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (3) @(negedge clk);
      check("mid_busy", busy3, 1);
      rst = 1;
      #1;
      check("abort_outs", {out_valid3, busy3, ovf3}, 3'b000);
      check("abort_bcd", bcd3, 12'h000);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      convert(8'd63, 12'h063, 8'h63, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
